synth_cmd_decoder: RTL

SYNTH_CMD_DECODER -- requirements
Module: synth_cmd_decoder

---
 rtl/synth_cmd_decoder.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/synth_cmd_decoder.sv
`default_nettype none
// ============================================================================
// Module      : synth_cmd_decoder
// Description : Byte-stream command decoder driving modulator, synth shift and
//               a small polyphonic voice allocator.
// Revision    : 1.0 - initial release
// ============================================================================
module synth_cmd_decoder #(
   parameter int N_VOICES       = 4,
   parameter int TIMEOUT_CYCLES = 1_000_000
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [7:0]              rx_data,
   input  logic                    rx_data_valid,
   output logic                    rx_data_ready,
   output logic [23:0]             mod_fcw,
   output logic [4:0]              mod_shift,
   output logic [4:0]              synth_shift,
   output logic [24*N_VOICES-1:0]  carrier_fcws,
   output logic [N_VOICES-1:0]     note_en,
   output logic                    cmd_error
);

   localparam int          TW           = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);

   localparam logic [2:0] OP_MOD_FCW    = 3'd1;
   localparam logic [2:0] OP_MOD_SHIFT  = 3'd2;
   localparam logic [2:0] OP_NOTE_START = 3'd3;
   localparam logic [2:0] OP_NOTE_STOP  = 3'd4;
   localparam logic [2:0] OP_SYN_SHIFT  = 3'd5;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ARG  = 2'd1,
      ST_EXEC = 2'd2
   } state_t;

   state_t                        state_q, state_d;
   logic [2:0]                    op_q, op_d;
   logic [1:0]                    nargs_q, nargs_d;
   logic [1:0]                    idx_q, idx_d;
   logic [23:0]                   arg_q, arg_d;
   logic [TW-1:0]                 tmr_q, tmr_d;
   logic                          err_q, err_d;
   logic [23:0]                   mod_fcw_q, mod_fcw_d;
   logic [4:0]                    mod_shift_q, mod_shift_d;
   logic [4:0]                    syn_shift_q, syn_shift_d;
   logic [N_VOICES-1:0][23:0]     fcw_q, fcw_d;
   logic [N_VOICES-1:0]           en_q, en_d;

   logic                          w_xfer;
   logic [N_VOICES-1:0]           w_match;
   logic [N_VOICES-1:0]           w_free_oh;
   logic                          w_start_fail;

   function automatic logic [4:0] sat5(input logic [7:0] a);
      return (a > 8'd31) ? 5'd31 : a[4:0];
   endfunction

   assign rx_data_ready = ~rst & (state_q != ST_EXEC);
   assign w_xfer        = rx_data_valid & rx_data_ready;

   generate
      for (genvar v = 0; v < N_VOICES; v++) begin : g_voice
         assign w_match[v] = en_q[v] && (fcw_q[v] == arg_q);
      end
   endgenerate

   // Isolates the lowest clear bit of the enable vector: the first free voice.
   assign w_free_oh    = ~en_q & (en_q + N_VOICES'(1));
   assign w_start_fail = (op_q == OP_NOTE_START) && !(|w_match) && (&en_q);

   always_comb begin
      state_d     = state_q;
      op_d        = op_q;
      nargs_d     = nargs_q;
      idx_d       = idx_q;
      arg_d       = arg_q;
      tmr_d       = tmr_q;
      err_d       = 1'b0;
      mod_fcw_d   = mod_fcw_q;
      mod_shift_d = mod_shift_q;
      syn_shift_d = syn_shift_q;
      fcw_d       = fcw_q;
      en_d        = en_q;

      case (state_q)
         ST_IDLE: begin
            if (w_xfer) begin
               if (rx_data >= 8'd1 && rx_data <= 8'd5) begin
                  state_d = ST_ARG;
                  op_d    = rx_data[2:0];
                  nargs_d = (rx_data == 8'd2 || rx_data == 8'd5) ? 2'd1 : 2'd3;
                  idx_d   = 2'd0;
                  arg_d   = 24'd0;
                  tmr_d   = '0;
               end else begin
                  err_d = 1'b1;
               end
            end
         end

         ST_ARG: begin
            if (w_xfer) begin
               case (idx_q)
                  2'd0:    arg_d[7:0]   = rx_data;
                  2'd1:    arg_d[15:8]  = rx_data;
                  default: arg_d[23:16] = rx_data;
               endcase
               tmr_d = '0;
               idx_d = idx_q + 2'd1;
               if (idx_q == nargs_q - 2'd1) begin
                  state_d = ST_EXEC;
               end
            end else if (tmr_q == TIMEOUT_LAST) begin
               state_d = ST_IDLE;
               tmr_d   = '0;
               err_d   = 1'b1;
            end else begin
               tmr_d = tmr_q + TW'(1);
            end
         end

         ST_EXEC: begin
            state_d = ST_IDLE;
            tmr_d   = '0;
            case (op_q)
               OP_MOD_FCW:   mod_fcw_d   = arg_q;
               OP_MOD_SHIFT: mod_shift_d = sat5(arg_q[7:0]);
               OP_SYN_SHIFT: syn_shift_d = sat5(arg_q[7:0]);
               OP_NOTE_START: begin
                  if (!(|w_match)) begin
                     for (int v = 0; v < N_VOICES; v++) begin
                        if (w_free_oh[v]) begin
                           fcw_d[v] = arg_q;
                           en_d[v]  = 1'b1;
                        end
                     end
                  end
               end
               OP_NOTE_STOP: en_d = en_q & ~w_match;
               default: ;
            endcase
         end

         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         op_q        <= 3'd0;
         nargs_q     <= 2'd0;
         idx_q       <= 2'd0;
         arg_q       <= 24'd0;
         tmr_q       <= '0;
         err_q       <= 1'b0;
         mod_fcw_q   <= 24'd0;
         mod_shift_q <= 5'd0;
         syn_shift_q <= 5'd0;
         fcw_q       <= '0;
         en_q        <= '0;
      end else begin
         state_q     <= state_d;
         op_q        <= op_d;
         nargs_q     <= nargs_d;
         idx_q       <= idx_d;
         arg_q       <= arg_d;
         tmr_q       <= tmr_d;
         err_q       <= err_d;
         mod_fcw_q   <= mod_fcw_d;
         mod_shift_q <= mod_shift_d;
         syn_shift_q <= syn_shift_d;
         fcw_q       <= fcw_d;
         en_q        <= en_d;
      end
   end

   // Allocation failure is flagged while the EXEC cycle is live.
   assign cmd_error    = err_q | ((state_q == ST_EXEC) && w_start_fail);
   assign mod_fcw      = mod_fcw_q;
   assign mod_shift    = mod_shift_q;
   assign synth_shift  = syn_shift_q;
   assign carrier_fcws = fcw_q;
   assign note_en      = en_q;

endmodule
`default_nettype wire
